// File: rtl/rp_operand_sequencer_pkg.sv
// rtl/rp_operand_sequencer_pkg.sv - shared constants and FSM state type for the RP operand sequencer
package rp_operand_sequencer_pkg;

    localparam int DATA_W      = 32;
    localparam int LATENCY_MAX = 15;
    // Counter wide enough for LATENCY_MAX.
    localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/rp_operand_sequencer_if.sv
// rtl/rp_operand_sequencer_if.sv - operand-pair input stream and result output stream
// Ports (signals):
//   s_valid/s_ready/s_ain/s_bin        operand pair stream, host -> sequencer
//   m_valid/m_ready/m_result/m_error   result stream, sequencer -> host
// master = host side, slave = sequencer side.
interface rp_operand_sequencer_if
    import rp_operand_sequencer_pkg::*;
    #(parameter int DATA_W = rp_operand_sequencer_pkg::DATA_W);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_ain;
    logic [DATA_W-1:0] s_bin;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_result;
    logic              m_error;

    modport master (
        output s_valid, s_ain, s_bin, m_ready,
        input  s_ready, m_valid, m_result, m_error
    );

    modport slave (
        input  s_valid, s_ain, s_bin, m_ready,
        output s_ready, m_valid, m_result, m_error
    );

endinterface

// File: rtl/rp_operand_sequencer_fifo.sv
// rtl/rp_operand_sequencer_fifo.sv - synchronous operand-pair FIFO (rp_op_fifo)
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   push, wdata         write strobe and data (ignored when full)
//   pop, rdata          read strobe (ignored when empty), head entry (show-ahead)
//   full, empty, level  status and occupancy
module rp_op_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through a valid count.
    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rp_operand_sequencer.sv
// rtl/rp_operand_sequencer.sv - feeds operand pairs to the math RP and returns its results
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   s (slave modport)       operand pair stream in, result stream out
//   rp_ain, rp_bin          operands to the RP (zero while decoupled)
//   rp_result               RP result, sampled LATENCY edges after operand load
//   rp_decouple             RP under reconfiguration
//   busy, level             activity flag and FIFO occupancy
module rp_operand_sequencer
    import rp_operand_sequencer_pkg::*;
#(
    parameter int DATA_W  = rp_operand_sequencer_pkg::DATA_W,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    rp_operand_sequencer_if.slave      s,
    output logic [DATA_W-1:0]          rp_ain,
    output logic [DATA_W-1:0]          rp_bin,
    input  logic [DATA_W-1:0]          rp_result,
    input  logic                       rp_decouple,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   op_a, op_b;
    logic [DATA_W-1:0]   m_result_q;
    logic                m_error_q;
    logic                m_valid_q;
    logic                push, pop, full, empty;
    logic [2*DATA_W-1:0] head;

    // s_ready is gated by reset so nothing is accepted while the FIFO is held clear.
    assign s.s_ready = Reset_n & ~full & ~rp_decouple;
    assign push      = s.s_valid & s.s_ready;
    assign s.m_valid  = m_valid_q;
    assign s.m_result = m_result_q;
    assign s.m_error  = m_error_q;

    rp_op_fifo #(.WIDTH(2*DATA_W), .DEPTH(DEPTH)) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (push),
        .wdata   ({s.s_ain, s.s_bin}),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty && !rp_decouple)               state_d = WAIT;
            WAIT:    if (rp_decouple || cnt_q == CNT_W'(1))    state_d = OUT;
            OUT:     if (s.m_ready)                            state_d = IDLE;
            default:                                           state_d = IDLE;
        endcase
    end

    always_comb begin
        pop    = (state_q == IDLE) & ~empty & ~rp_decouple;
        busy   = (state_q != IDLE) | ~empty;
        rp_ain = rp_decouple ? '0 : op_a;
        rp_bin = rp_decouple ? '0 : op_b;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            op_a       <= '0;
            op_b       <= '0;
            cnt_q      <= '0;
            m_result_q <= '0;
            m_error_q  <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    op_a  <= head[2*DATA_W-1:DATA_W];
                    op_b  <= head[DATA_W-1:0];
                    cnt_q <= CNT_W'(LATENCY);
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Decouple wins even on the sample cycle: the RP output is untrustworthy.
                    if (rp_decouple) begin
                        m_result_q <= '0;
                        m_error_q  <= 1'b1;
                        m_valid_q  <= 1'b1;
                    end else if (cnt_q == CNT_W'(1)) begin
                        m_result_q <= rp_result;
                        m_error_q  <= 1'b0;
                        m_valid_q  <= 1'b1;
                    end
                end
                OUT: if (s.m_ready) m_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rp_operand_sequencer.sv
// tb/tb_rp_operand_sequencer.sv - directed self-checking bench for rp_operand_sequencer
module tb_rp_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rp_decouple = 1'b0;
    logic [31:0] rp_ain, rp_bin, rp_result;
    logic        busy;
    logic [2:0]  level;
    logic [31:0] rp_pipe;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    rp_operand_sequencer_if #(.DATA_W(32)) bus ();

    rp_operand_sequencer #(.DATA_W(32), .DEPTH(4), .LATENCY(2)) dut (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .s           (bus),
        .rp_ain      (rp_ain),
        .rp_bin      (rp_bin),
        .rp_result   (rp_result),
        .rp_decouple (rp_decouple),
        .busy        (busy),
        .level       (level)
    );

    always #5 clk = ~clk;

    // RP model: one registered adder stage, so the sum is on rp_result by the sampling edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rp_pipe <= 32'd0;
        else        rp_pipe <= rp_ain + rp_bin;
    end
    assign rp_result = rp_pipe;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int g = 0;
        bus.s_ain = a;
        bus.s_bin = b;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && g < 100) begin
            step();
            g++;
        end
        if (!bus.s_ready) begin
            check("push_timeout", 64'(0), 64'(1));
        end else begin
            step();
            exp_q.push_back(a + b);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int g = 0;
        while (!bus.m_valid && g < 100) begin
            step();
            g++;
        end
        if (!bus.m_valid) check(tag, 64'(0), 64'(1));
    endtask

    // Consumes n results in order, also completing any pending s_valid transfer.
    task automatic drain(input int n, input string tag);
        int got = 0;
        int g = 0;
        logic acc;
        logic [31:0] exp;
        bus.m_ready = 1'b1;
        while (got < n && g < 200) begin
            acc = bus.s_valid & bus.s_ready;
            exp = bus.s_ain + bus.s_bin;
            if (bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected"}, 64'(bus.m_result), 64'(0));
                end else begin
                    check({tag, "_result"}, 64'(bus.m_result), 64'(exp_q.pop_front()));
                    check({tag, "_error"}, 64'(bus.m_error), 64'(0));
                end
                got++;
            end
            step();
            if (acc) begin
                exp_q.push_back(exp);
                bus.s_valid = 1'b0;
            end
            g++;
        end
        if (got < n) check({tag, "_timeout"}, 64'(got), 64'(n));
        bus.m_ready = 1'b0;
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_ain = 32'd0;
        bus.s_bin = 32'd0;
        bus.m_ready = 1'b0;

        // Reset state
        #2;
        check("rst_s_ready", 64'(bus.s_ready), 64'(0));
        #23 rst_n = 1'b1;
        step();
        check("rst_level", 64'(level), 64'(0));
        check("rst_m_valid", 64'(bus.m_valid), 64'(0));
        check("rst_m_result", 64'(bus.m_result), 64'(0));
        check("rst_m_error", 64'(bus.m_error), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rp_ain", 64'(rp_ain), 64'(0));
        check("rst_s_ready_after", 64'(bus.s_ready), 64'(1));

        // 1: single pair, latency 2
        bus.m_ready = 1'b1;
        push(32'd5, 32'd7);
        check("t1_level_push", 64'(level), 64'(1));
        step();
        check("t1_rp_ain", 64'(rp_ain), 64'(5));
        check("t1_rp_bin", 64'(rp_bin), 64'(7));
        check("t1_busy_wait", 64'(busy), 64'(1));
        check("t1_valid_e0", 64'(bus.m_valid), 64'(0));
        step();
        check("t1_valid_e1", 64'(bus.m_valid), 64'(0));
        step();
        check("t1_valid_e2", 64'(bus.m_valid), 64'(1));
        check("t1_result", 64'(bus.m_result), 64'(exp_q.pop_front()));
        check("t1_error", 64'(bus.m_error), 64'(0));
        step();
        check("t1_valid_drop", 64'(bus.m_valid), 64'(0));
        check("t1_busy_drop", 64'(busy), 64'(0));
        bus.m_ready = 1'b0;

        // 2: fill FIFO while stalled, sixth pair held back
        push(32'd1, 32'd2);
        push(32'd3, 32'd4);
        push(32'd5, 32'd6);
        push(32'd7, 32'd8);
        push(32'd9, 32'd10);
        check("t2_level_full", 64'(level), 64'(4));
        check("t2_s_ready_full", 64'(bus.s_ready), 64'(0));
        bus.s_ain = 32'd11;
        bus.s_bin = 32'd12;
        bus.s_valid = 1'b1;
        repeat (3) step();
        check("t2_level_held", 64'(level), 64'(4));
        check("t2_s_ready_held", 64'(bus.s_ready), 64'(0));
        drain(6, "t2");

        // 3: hold in OUT for 10 cycles
        push(32'd20, 32'd22);
        push(32'd1, 32'd1);
        wait_valid("t3_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_result", 64'(bus.m_result), 64'(42));
            check("t3_hold_rp_ain", 64'(rp_ain), 64'(20));
            step();
        end
        check("t3_hold_valid", 64'(bus.m_valid), 64'(1));
        check("t3_hold_error", 64'(bus.m_error), 64'(0));
        check("t3_no_pop", 64'(level), 64'(1));
        drain(2, "t3");

        // 4: decouple in the second WAIT cycle
        push(32'd100, 32'd1);
        push(32'd2, 32'd3);
        step();
        rp_decouple = 1'b1;
        #1;
        check("t4_rp_ain_zero", 64'(rp_ain), 64'(0));
        check("t4_rp_bin_zero", 64'(rp_bin), 64'(0));
        check("t4_s_ready_dec", 64'(bus.s_ready), 64'(0));
        step();
        check("t4_abort_valid", 64'(bus.m_valid), 64'(1));
        check("t4_abort_error", 64'(bus.m_error), 64'(1));
        check("t4_abort_result", 64'(bus.m_result), 64'(0));
        void'(exp_q.pop_front());
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        repeat (2) step();
        check("t4_dec_valid", 64'(bus.m_valid), 64'(0));
        check("t4_dec_level", 64'(level), 64'(1));
        rp_decouple = 1'b0;
        drain(1, "t4");

        // 5: simultaneous push and pop at level 2
        push(32'd1, 32'd1);
        push(32'd2, 32'd2);
        push(32'd3, 32'd3);
        wait_valid("t5_valid_timeout");
        check("t5_level_pre", 64'(level), 64'(2));
        check("t5_first", 64'(bus.m_result), 64'(exp_q.pop_front()));
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        check("t5_level_idle", 64'(level), 64'(2));
        bus.s_ain = 32'd4;
        bus.s_bin = 32'd4;
        bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        exp_q.push_back(32'd8);
        check("t5_level_same", 64'(level), 64'(2));
        check("t5_rp_ain", 64'(rp_ain), 64'(2));
        drain(3, "t5");

        // 6: reset mid-WAIT with 3 queued
        push(32'd10, 32'd10);
        push(32'd1, 32'd0);
        push(32'd2, 32'd0);
        push(32'd3, 32'd0);
        push(32'd4, 32'd0);
        wait_valid("t6_valid_timeout");
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        step();
        check("t6_pre_level", 64'(level), 64'(3));
        check("t6_pre_rp_ain", 64'(rp_ain), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_level", 64'(level), 64'(0));
        check("t6_rst_m_valid", 64'(bus.m_valid), 64'(0));
        check("t6_rst_m_result", 64'(bus.m_result), 64'(0));
        check("t6_rst_m_error", 64'(bus.m_error), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_rp_ain", 64'(rp_ain), 64'(0));
        check("t6_rst_s_ready", 64'(bus.s_ready), 64'(0));
        exp_q.delete();
        #10 rst_n = 1'b1;
        step();
        check("t6_post_level", 64'(level), 64'(0));
        push(32'd9, 32'd9);
        drain(1, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
